// File: rtl/i2c_req_arbiter_pkg.sv
// Shared types and constants for the I2C request arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package i2c_arb_pkg;

  localparam int DEV_W = 7;
  localparam int REG_W = 8;
  localparam int DAT_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Arbiter sequencing: pick, accept, start master, wait for completion, answer.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } arb_state_t;

  // One register-level command as presented to the I2C master.
  typedef struct packed {
    logic [DEV_W-1:0] dev_addr;
    logic [REG_W-1:0] reg_addr;
    logic [DAT_W-1:0] data;
    logic             rw;
  } cmd_t;

endpackage

// File: rtl/i2c_req_arbiter_rr_arbiter.sv
// Round-robin winner select: first requesting bit at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the parent decides when a grant is taken.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             gnt_any
);

  logic [IDX_W:0] cand;

  // Scan from farthest to nearest candidate so the one closest to ptr is kept last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    gnt_any   = 1'b0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (req[cand[IDX_W-1:0]]) begin
        grant                   = '0;
        grant[cand[IDX_W-1:0]]  = 1'b1;
        grant_idx               = cand[IDX_W-1:0];
        gnt_any                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master among N_REQ requesters with round-robin command arbitration.
// Latency: req_valid at cycle 0 -> req_ready at 1 -> m_start at 2 (idle master); rsp_valid 1 cycle after m_done.
// Backpressure: requests wait outside IDLE; m_start is withheld while m_busy is high; timeout bounds WAIT.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [DEV_W*N_REQ-1:0] req_dev_addr,
  input  logic [REG_W*N_REQ-1:0] req_reg_addr,
  input  logic [DAT_W*N_REQ-1:0] req_wdata,
  input  logic [N_REQ-1:0]       req_rw,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [DAT_W-1:0]       rsp_rdata,
  output logic                   rsp_err,
  output logic                   m_start,
  output logic [DEV_W-1:0]       m_dev_addr,
  output logic [REG_W-1:0]       m_reg_addr,
  output logic [DAT_W-1:0]       m_data,
  output logic                   m_rw,
  input  logic                   m_busy,
  input  logic                   m_done,
  input  logic [DAT_W-1:0]       m_rdata,
  input  logic                   m_nack
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [TMR_W-1:0] TMR_MAX   = '1;
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt_oh;
  cmd_t             cmd;
  cmd_t             slice_cmd;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic             timeout_hit;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .gnt_any   (arb_any)
  );

  // Command fields of the granted requester, sampled during its accept cycle.
  always_comb begin
    slice_cmd          = '0;
    slice_cmd.dev_addr = req_dev_addr[DEV_W*gnt_idx +: DEV_W];
    slice_cmd.reg_addr = req_reg_addr[REG_W*gnt_idx +: REG_W];
    slice_cmd.data     = req_wdata[DAT_W*gnt_idx +: DAT_W];
    slice_cmd.rw       = req_rw[gnt_idx];
  end

  // Saturating next-count; the timeout fires once the count reaches TIMEOUT_CYC.
  always_comb begin
    timer_nxt = timer;
    if (timer != TMR_MAX) begin
      timer_nxt = timer + 1'b1;
    end
  end

  assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_nxt >= TMR_LIMIT);

  assign m_dev_addr = cmd.dev_addr;
  assign m_reg_addr = cmd.reg_addr;
  assign m_data     = cmd.data;
  assign m_rw       = cmd.rw;

  // Arbitration FSM with registered handshake, master and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt_oh    <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      m_start   <= 1'b0;
      cmd       <= '0;
      timer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt_idx   <= arb_idx;
            gnt_oh    <= arb_grant;
            req_ready <= arb_grant;
            state     <= LATCH;
          end
        end
        LATCH: begin
          req_ready <= '0;
          cmd       <= slice_cmd;
          // An idle master lets the start pulse coincide with the first ISSUE cycle.
          if (!m_busy) begin
            m_start <= 1'b1;
            timer   <= '0;
          end
          state <= ISSUE;
        end
        ISSUE: begin
          if (m_start) begin
            // The start cycle itself counts toward the timeout.
            m_start <= 1'b0;
            timer   <= timer_nxt;
            state   <= WAIT;
          end else if (!m_busy) begin
            m_start <= 1'b1;
            timer   <= '0;
          end
        end
        WAIT: begin
          timer <= timer_nxt;
          if (m_done) begin
            rsp_valid <= gnt_oh;
            rsp_err   <= m_nack;
            rsp_rdata <= (cmd.rw == RW_READ && !m_nack) ? m_rdata : '0;
            state     <= RESP;
          end else if (timeout_hit) begin
            rsp_valid <= gnt_oh;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= '0;
          ptr       <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
